// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART byte receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined)
// feeding a first-word-fall-through receive FIFO with frame/parity/overflow pulses.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_frame_err,
    output logic                          o_parity_err,
    output logic                          o_overflow
);
    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
    logic par_bad, par_bad_n, parity_err_n;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shift, shift_n;
    logic rx_meta, rx_s, rx_prev;
    logic push, accept, pop, frame_err_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_comb begin
        state_n     = state;
        cnt_n       = cnt + 1'b1;
        bit_cnt_n   = bit_cnt;
        shift_n     = shift;
        push        = 1'b0;
        frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n    = par_bad;
        parity_err_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (rx_prev && !rx_s) begin
                    state_n   = START;
                    bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_n = 1'b0;
`endif
                end
            end
            START: if (cnt == CW'(HALF - 1)) begin
                cnt_n   = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == CW'(CPB - 1)) begin
                cnt_n     = '0;
                shift_n   = {rx_s, shift[7:1]};
                bit_cnt_n = bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                if (bit_cnt == 3'd7) state_n = PARITY;
`else
                if (bit_cnt == 3'd7) state_n = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (cnt == CW'(CPB - 1)) begin
                cnt_n     = '0;
                par_bad_n = ^{shift, rx_s};
                state_n   = STOP;
            end
`endif
            STOP: if (cnt == CW'(CPB - 1)) begin
                cnt_n = '0;
                // A low stop bit means a break or misalignment: wait for idle before rearming
                if (!rx_s) begin
                    frame_err_n = 1'b1;
                    state_n     = WAIT_HIGH;
                end
`ifdef UART_RX_PARITY_EN
                else if (par_bad) begin
                    parity_err_n = 1'b1;
                    state_n      = IDLE;
                end
`endif
                else begin
                    push    = 1'b1;
                    state_n = IDLE;
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    assign o_valid = o_count != '0;
    assign o_data  = o_valid ? mem[rd_ptr] : 8'h00;
    assign pop     = o_valid && i_ready;
    assign accept  = push && (o_count < (AW + 1)'(FIFO_DEPTH) || pop);
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            rx_meta     <= 1'b0;
            rx_s        <= 1'b0;
            rx_prev     <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_count     <= '0;
            o_frame_err <= 1'b0;
            o_overflow  <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            bit_cnt     <= bit_cnt_n;
            shift       <= shift_n;
            rx_meta     <= uart_rx;
            rx_s        <= rx_meta;
            rx_prev     <= rx_s;
            wr_ptr      <= wr_ptr + AW'(accept);
            rd_ptr      <= rd_ptr + AW'(pop);
            o_count     <= o_count + (AW + 1)'(accept) - (AW + 1)'(pop);
            o_frame_err <= frame_err_n;
            o_overflow  <= push && !accept;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= shift;
    end
`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad      <= 1'b0;
            o_parity_err <= 1'b0;
        end else begin
            par_bad      <= par_bad_n;
            o_parity_err <= parity_err_n;
        end
    end
`else
    assign o_parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed frames into uart_rx_fifo; expected bytes go into a queue
// that a negedge monitor pops on every accepted output, plus error-pulse tallies.
module tb_uart_rx_fifo;
    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 115200;
    localparam int DEPTH    = 8;
    localparam int CPB      = CLK_FREQ / BAUD;
    localparam int H        = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    logic clk = 1'b0, rst = 1'b1, uart_rx = 1'b1, i_ready = 1'b1;
    logic [7:0] o_data;
    logic o_valid, o_frame_err, o_parity_err, o_overflow;
    logic [$clog2(DEPTH):0] o_count;
    logic [7:0] q [$];
    logic [7:0] exp_b;
    int total = 0, bad = 0, cyc = 0;
    int n_frame = 0, n_par = 0, n_ovf = 0, max_cnt = 0, first_valid = -1;
    int f0, p0, v0;
    uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .o_data(o_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_count(o_count), .o_frame_err(o_frame_err),
        .o_parity_err(o_parity_err), .o_overflow(o_overflow)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (!rst) begin
            if (o_frame_err) n_frame++;
            if (o_parity_err) n_par++;
            if (o_overflow) n_ovf++;
            if (int'(o_count) > max_cnt) max_cnt = int'(o_count);
            if (o_valid && first_valid < 0) first_valid = cyc;
            if (o_valid && i_ready) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL pop_unexpected got=%h expected=none", o_data);
                end else begin
                    exp_b = q.pop_front();
                    if (o_data !== exp_b) begin
                        bad++;
                        $display("FAIL pop_data got=%h expected=%h", o_data, exp_b);
                    end
                end
            end
        end
    end
    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask
    function automatic logic [10:0] frame(input logic [7:0] b, input logic stop);
`ifdef UART_RX_PARITY_EN
        return {stop, ^b, b, 1'b0};
`else
        return {1'b1, stop, b, 1'b0};
`endif
    endfunction
    task automatic send(input logic [10:0] f);
        for (int i = 0; i < NB; i++) begin
            uart_rx = f[i];
            tick(CPB);
        end
    endtask
    task automatic snap();
        f0 = n_frame;
        p0 = n_par;
        v0 = n_ovf;
    endtask
    task automatic no_errs(input string name);
        check({name, "_frame"}, n_frame - f0, 0);
        check({name, "_parity"}, n_par - p0, 0);
        check({name, "_ovf"}, n_ovf - v0, 0);
    endtask
    initial begin
        #1_200_000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
    initial begin
        logic [10:0] f;
        int t0;
        tick(5);
        rst = 1'b0;
        tick(1);
        check("rst_valid", int'(o_valid), 0);
        check("rst_count", int'(o_count), 0);
        check("rst_data", int'(o_data), 0);
        check("rst_pulses", int'({o_frame_err, o_parity_err, o_overflow}), 0);
        tick(20);
        // single byte, output latency from the line's falling edge
        snap();
        t0 = cyc;
        q.push_back(8'h55);
        send(frame(8'h55, 1'b1));
        tick(H + 10);
        check("latency", first_valid, t0 + H + (NB - 1) * CPB + 3);
        check("single_drained", q.size(), 0);
        no_errs("single");
        // fill past capacity with back-to-back frames
        snap();
        i_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k <= DEPTH) q.push_back(8'(k));
            send(frame(8'(k), 1'b1));
        end
        tick(H);
        check("full_count", int'(o_count), DEPTH);
        check("full_max", max_cnt, DEPTH);
        check("full_ovf", n_ovf - v0, 1);
        i_ready = 1'b1;
        tick(20);
        check("drain_count", int'(o_count), 0);
        check("drain_queue", q.size(), 0);
        // bad stop bit followed by a held-low line, then a normal byte
        snap();
        send(frame(8'hA3, 1'b0));
        tick(3 * CPB);
        uart_rx = 1'b1;
        tick(CPB);
        check("brk_frame", n_frame - f0, 1);
        check("brk_count", int'(o_count), 0);
        q.push_back(8'h3C);
        send(frame(8'h3C, 1'b1));
        tick(H + 10);
        check("brk_frame_once", n_frame - f0, 1);
        check("brk_next", q.size(), 0);
        // short low glitch must not start a frame
        snap();
        uart_rx = 1'b0;
        tick(200);
        uart_rx = 1'b1;
        tick(2 * CPB);
        check("glitch_count", int'(o_count), 0);
        no_errs("glitch");
        q.push_back(8'h5A);
        send(frame(8'h5A, 1'b1));
        tick(H + 10);
        check("glitch_next", q.size(), 0);
        // reset in the middle of data bit 4
        snap();
        f = frame(8'h0F, 1'b1);
        for (int i = 0; i < 5; i++) begin
            uart_rx = f[i];
            tick(CPB);
        end
        uart_rx = f[5];
        tick(H);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_rst_count", int'(o_count), 0);
        check("mid_rst_valid", int'(o_valid), 0);
        tick(CPB - H - 1);
        for (int i = 6; i < NB; i++) begin
            uart_rx = f[i];
            tick(CPB);
        end
        tick(CPB);
        check("mid_rst_nobyte", int'(o_count), 0);
        q.push_back(8'h7E);
        send(frame(8'h7E, 1'b1));
        tick(H + 10);
        check("mid_rst_next", q.size(), 0);
        no_errs("mid_rst");
`ifdef UART_RX_PARITY_EN
        snap();
        send({1'b1, 1'b1, 8'h0F, 1'b0});
        tick(H + 10);
        check("par_bad_pulse", n_par - p0, 1);
        check("par_bad_count", int'(o_count), 0);
        q.push_back(8'h0F);
        send({1'b1, 1'b0, 8'h0F, 1'b0});
        tick(H + 10);
        check("par_good_pulse", n_par - p0, 1);
        check("par_good_byte", q.size(), 0);
`endif
        check("final_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
